// File: rtl/text_line_fetcher.sv
// Per-scanline glyph fetcher for the debug text display: text RAM -> char ROM -> 1-bit pixel stream.
// Both memories are synchronous with one cycle of read latency.
module text_line_fetcher #(
  parameter int COLS   = 80,
  parameter int TXT_AW = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [6:0]        text_row,
  input  logic [3:0]        font_row,
  input  logic              pix_en,
  output logic [TXT_AW-1:0] txt_addr,
  input  logic [7:0]        txt_data,
  output logic [11:0]       rom_addr,
  input  logic [7:0]        rom_data,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              busy,
  output logic              underrun
);

  typedef enum logic [2:0] {IDLE, TXT, CHR, CAP, WAIT} state_t;

  localparam logic [7:0] COLS8 = 8'(COLS);

  state_t            state;
  logic [TXT_AW-1:0] base;
  logic [TXT_AW-1:0] row_base;
  logic [7:0]        column;
  logic [7:0]        emitted;
  logic [7:0]        hold;
  logic              hold_full;
  logic [7:0]        shifter;
  logic [3:0]        cnt;
  logic [3:0]        font_q;
  logic [11:0]       rom_addr_q;
  logic              line_done;

  assign row_base = TXT_AW'(32'(text_row) * 32'(COLS));

  // txt_data only arrives during CHR, so the ROM address is forwarded from it
  // combinationally in that state and held from a register everywhere else.
  assign rom_addr = (state == CHR) ? {txt_data, font_q} : rom_addr_q;

  // Drop busy together with the final shift of the last glyph.
  assign line_done = (state == IDLE) && (emitted == COLS8) &&
                     ((cnt == 4'd0) || ((cnt == 4'd1) && pix_en));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base        <= '0;
      column      <= '0;
      emitted     <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      shifter     <= '0;
      cnt         <= '0;
      font_q      <= '0;
      rom_addr_q  <= '0;
      txt_addr    <= '0;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
    end else if (line_start) begin
      font_q      <= font_row;
      base        <= row_base;
      column      <= '0;
      hold_full   <= 1'b0;
      cnt         <= '0;
      emitted     <= '0;
      underrun    <= 1'b0;
      txt_addr    <= row_base;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      busy        <= 1'b1;
      state       <= TXT;
    end else begin
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      if (pix_en) begin
        if (cnt != 4'd0) begin
          pixel       <= shifter[7];
          shifter     <= {shifter[6:0], 1'b0};
          cnt         <= cnt - 4'd1;
          pixel_valid <= 1'b1;
        end else if (hold_full) begin
          pixel       <= hold[7];
          shifter     <= {hold[6:0], 1'b0};
          cnt         <= 4'd7;
          hold_full   <= 1'b0;
          emitted     <= emitted + 8'd1;
          pixel_valid <= 1'b1;
        end else if (busy && (emitted < COLS8)) begin
          underrun <= 1'b1;
        end
      end

      if (line_done) busy <= 1'b0;

      case (state)
        TXT: state <= CHR;
        CHR: begin
          rom_addr_q <= {txt_data, font_q};
          column     <= column + 8'd1;
          state      <= CAP;
        end
        CAP: begin
          hold      <= rom_data;
          hold_full <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (!hold_full) begin
            if (column == COLS8) begin
              state <= IDLE;
            end else begin
              txt_addr <= base + TXT_AW'(column);
              state    <= TXT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_line_fetcher.sv
// Directed bench for text_line_fetcher: text RAM and char ROM are modelled as 1-cycle synchronous memories.
module tb_text_line_fetcher;

  logic        clk = 1'b0;
  logic        reset, line_start, pix_en;
  logic [6:0]  text_row;
  logic [3:0]  font_row;
  logic [10:0] txt_addr;
  logic [7:0]  txt_data, rom_data;
  logic [11:0] rom_addr;
  logic        pixel, pixel_valid, busy, underrun;

  logic        l_start;
  logic [6:0]  l_row;
  logic [10:0] l_txt_addr;
  logic [11:0] l_rom_addr;
  logic        l_pixel, l_valid, l_busy, l_under;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [0:2047];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [11:0] a);
    return a[11:4] ^ {a[3:0], ~a[3:0]};
  endfunction

  always @(posedge clk) begin
    txt_data <= mem[txt_addr];
    rom_data <= rom_byte(rom_addr);
  end

  text_line_fetcher #(.COLS(4), .TXT_AW(11)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .text_row(text_row),
    .font_row(font_row), .pix_en(pix_en), .txt_addr(txt_addr), .txt_data(txt_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .pixel(pixel), .pixel_valid(pixel_valid),
    .busy(busy), .underrun(underrun)
  );

  text_line_fetcher #(.COLS(80), .TXT_AW(11)) dut80 (
    .clk(clk), .reset(reset), .line_start(l_start), .text_row(l_row),
    .font_row(4'h0), .pix_en(1'b0), .txt_addr(l_txt_addr), .txt_data(8'h00),
    .rom_addr(l_rom_addr), .rom_data(8'h00), .pixel(l_pixel), .pixel_valid(l_valid),
    .busy(l_busy), .underrun(l_under)
  );

  task automatic test_reset();
    reset = 1'b1; line_start = 1'b0; pix_en = 1'b0; text_row = '0; font_row = '0;
    l_start = 1'b0; l_row = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (txt_addr !== 11'd0) begin n_fail++; $display("FAIL reset_txt_addr got %0h exp 0", txt_addr); end
    n_tests++;
    if (rom_addr !== 12'd0) begin n_fail++; $display("FAIL reset_rom_addr got %0h exp 0", rom_addr); end
    n_tests++;
    if ({pixel, pixel_valid, busy, underrun} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {pixel, pixel_valid, busy, underrun});
    end
    reset = 1'b0;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({pixel_valid, underrun} !== 2'b00) begin
      n_fail++; $display("FAIL idle_pix_en got valid/underrun %b exp 00", {pixel_valid, underrun});
    end
  endtask

  task automatic test_line();
    logic [31:0] got, expv;
    logic [11:0] prev;
    logic [7:0]  ch;
    logic [11:0] ra [$];
    int nv;
    got = '0; expv = '0; nv = 0;
    @(negedge clk); line_start = 1'b1; text_row = 7'd0; font_row = 4'd3; pix_en = 1'b0;
    prev = rom_addr;
    @(negedge clk); line_start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL line_busy got %b exp 1", busy); end
    n_tests++;
    if (txt_addr !== 11'd0) begin n_fail++; $display("FAIL line_txt_addr got %0d exp 0", txt_addr); end
    for (int c = 2; c < 50; c++) begin
      @(negedge clk);
      if (rom_addr !== prev) begin ra.push_back(rom_addr); prev = rom_addr; end
      if (pixel_valid === 1'b1) begin got = {got[30:0], pixel}; nv++; end
      if (c == 4) pix_en = 1'b1;
    end
    pix_en = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ch = 8'h41 + 8'(g);
      expv = {expv[23:0], rom_byte({ch, 4'd3})};
    end
    n_tests++;
    if (ra.size() != 4) begin n_fail++; $display("FAIL line_rom_addr_count got %0d exp 4", ra.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        ch = 8'h41 + 8'(i);
        n_tests++;
        if (ra[i] !== {ch, 4'd3}) begin
          n_fail++; $display("FAIL line_rom_addr[%0d] got %0h exp %0h", i, ra[i], {ch, 4'd3});
        end
      end
    end
    n_tests++;
    if (nv != 32) begin n_fail++; $display("FAIL line_pixel_count got %0d exp 32", nv); end
    n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL line_pixels got %h exp %h", got, expv); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL line_busy_end got %b exp 0", busy); end
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL line_underrun got %b exp 0", underrun); end
  endtask

  task automatic test_addr();
    @(negedge clk); l_start = 1'b1; l_row = 7'd2;
    @(negedge clk); l_start = 1'b0;
    n_tests++;
    if (l_txt_addr !== 11'd160) begin n_fail++; $display("FAIL addr_row2 got %0d exp 160", l_txt_addr); end
    @(negedge clk); l_start = 1'b1; l_row = 7'd30;
    @(negedge clk); l_start = 1'b0;
    n_tests++;
    if (l_txt_addr !== 11'd352) begin n_fail++; $display("FAIL addr_row30_wrap got %0d exp 352", l_txt_addr); end
  endtask

  task automatic test_underrun();
    @(negedge clk); line_start = 1'b1; text_row = 7'd1; font_row = 4'd0; pix_en = 1'b0;
    @(negedge clk); line_start = 1'b0;
    @(negedge clk); pix_en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL early_pix_underrun got %b exp 1", underrun); end
    n_tests++;
    if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL early_pix_valid0 got %b exp 0", pixel_valid); end
    @(negedge clk); pix_en = 1'b0;
    n_tests++;
    if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL early_pix_valid1 got %b exp 0", pixel_valid); end
    repeat (2) @(negedge clk);
    n_tests++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky got %b exp 1", underrun); end
    line_start = 1'b1; text_row = 7'd0;
    @(negedge clk); line_start = 1'b0;
    n_tests++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear got %b exp 0", underrun); end
  endtask

  task automatic test_slow();
    logic [31:0] got, expv;
    logic [7:0]  ch;
    int nv;
    got = '0; expv = '0; nv = 0;
    @(negedge clk); line_start = 1'b1; text_row = 7'd0; font_row = 4'd5; pix_en = 1'b0;
    @(negedge clk); line_start = 1'b0;
    for (int c = 2; c < 120; c++) begin
      @(negedge clk);
      if (pixel_valid === 1'b1) begin got = {got[30:0], pixel}; nv++; end
      pix_en = (c >= 4) && (((c - 4) % 3) == 0);
    end
    pix_en = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ch = 8'h41 + 8'(g);
      expv = {expv[23:0], rom_byte({ch, 4'd5})};
    end
    n_tests++;
    if (nv != 32) begin n_fail++; $display("FAIL slow_pixel_count got %0d exp 32", nv); end
    n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL slow_pixels got %h exp %h", got, expv); end
    n_tests++;
    if ({busy, underrun} !== 2'b00) begin n_fail++; $display("FAIL slow_end got busy/underrun %b exp 00", {busy, underrun}); end
  endtask

  task automatic test_abort();
    logic [7:0] gb, eb;
    eb = rom_byte({8'h51, 4'd7});
    gb = '0;
    @(negedge clk); line_start = 1'b1; text_row = 7'd0; font_row = 4'd3; pix_en = 1'b0;
    @(negedge clk); line_start = 1'b0;
    for (int c = 2; c < 14; c++) begin
      @(negedge clk);
      if (c == 4) pix_en = 1'b1;
    end
    @(negedge clk); line_start = 1'b1; text_row = 7'd2; font_row = 4'd7;
    @(negedge clk); line_start = 1'b0; pix_en = 1'b0;
    n_tests++;
    if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL abort_pix_ignored got %b exp 0", pixel_valid); end
    n_tests++;
    if (txt_addr !== 11'd8) begin n_fail++; $display("FAIL abort_txt_addr got %0d exp 8", txt_addr); end
    n_tests++;
    if ({busy, underrun} !== 2'b10) begin n_fail++; $display("FAIL abort_flags got busy/underrun %b exp 10", {busy, underrun}); end
    @(negedge clk);
    n_tests++;
    if (rom_addr !== 12'h517) begin n_fail++; $display("FAIL abort_rom_addr got %0h exp 517", rom_addr); end
    repeat (2) @(negedge clk);
    pix_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_tests++;
        if (pixel_valid !== 1'b1 || pixel !== eb[7]) begin
          n_fail++; $display("FAIL abort_first_pixel got v=%b p=%b exp v=1 p=%b", pixel_valid, pixel, eb[7]);
        end
      end
      gb = {gb[6:0], pixel};
    end
    pix_en = 1'b0;
    n_tests++;
    if (gb !== eb) begin n_fail++; $display("FAIL abort_glyph got %h exp %h", gb, eb); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] gb, eb;
    eb = rom_byte(12'h612);
    gb = '0;
    @(negedge clk); line_start = 1'b1; text_row = 7'd0; font_row = 4'd3; pix_en = 1'b0;
    @(negedge clk); line_start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rom_addr !== 12'h413) begin n_fail++; $display("FAIL rmid_pre_rom_addr got %0h exp 413", rom_addr); end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_tests++;
    if ({txt_addr, rom_addr} !== 23'd0) begin
      n_fail++; $display("FAIL rmid_addrs got txt=%0h rom=%0h exp 0 0", txt_addr, rom_addr);
    end
    n_tests++;
    if ({pixel, pixel_valid, busy, underrun} !== 4'b0000) begin
      n_fail++; $display("FAIL rmid_flags got %b exp 0000", {pixel, pixel_valid, busy, underrun});
    end
    @(negedge clk); line_start = 1'b1; text_row = 7'd1; font_row = 4'd2;
    @(negedge clk); line_start = 1'b0;
    n_tests++;
    if (txt_addr !== 11'd4 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rmid_restart got txt=%0d busy=%b exp 4 1", txt_addr, busy);
    end
    @(negedge clk);
    n_tests++;
    if (rom_addr !== 12'h612) begin n_fail++; $display("FAIL rmid_rom_addr got %0h exp 612", rom_addr); end
    repeat (2) @(negedge clk);
    pix_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gb = {gb[6:0], pixel};
    end
    n_tests++;
    if (gb !== eb || pixel_valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_glyph got %h v=%b exp %h v=1", gb, pixel_valid, eb);
    end
    repeat (30) @(negedge clk);
    pix_en = 1'b0;
    n_tests++;
    if ({busy, underrun} !== 2'b00) begin n_fail++; $display("FAIL rmid_end got busy/underrun %b exp 00", {busy, underrun}); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      mem[i]     = 8'h41 + 8'(i);
      mem[4 + i] = 8'h61 + 8'(i);
      mem[8 + i] = 8'h51 + 8'(i);
    end
    test_reset();
    test_line();
    test_addr();
    test_underrun();
    test_slow();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/text_line_fetcher.md
# text_line_fetcher

Sequences per-scanline glyph fetches for the debug text display: for each active line it reads character codes from the text buffer RAM and font rows from the 4k×8 character ROM, then serializes each font byte into a 1-bit pixel stream. It sits between the video timing generator (line/pixel strobes) and the text RAM and char ROM, and is the only master of the char ROM address port. The char ROM and text RAM are both synchronous with 1-cycle read latency.

## Interface
- COLS, 80: characters per text line (1..255).
- TXT_AW, 11: text RAM address width.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- line_start  in  1  one-cycle pulse: begin fetching a new line.
- text_row  in  7  text row index, sampled on line_start.
- font_row  in  4  glyph row 0..15, sampled on line_start.
- pix_en  in  1  pixel strobe: consume one pixel this cycle.
- txt_addr  out  TXT_AW  text RAM read address.
- txt_data  in  8  character code, valid the cycle after txt_addr.
- rom_addr  out  12  char ROM address = {char[7:0], font_row[3:0]}.
- rom_data  in  8  font byte, valid the cycle after rom_addr.
- pixel  out  1  current pixel, MSB of font byte first.
- pixel_valid  out  1  pixel carries a real glyph bit.
- busy  out  1  line in progress (fetching or pixels remaining).
- underrun  out  1  sticky: pix_en arrived with no pixel available.

## Operation
- Registers: base address, column counter (glyphs fetched), hold register + hold_full flag, 8-bit shifter + 4-bit bit count, glyphs-emitted counter.
- line_start (any state): latch font_row, base = text_row*COLS mod 2^TXT_AW, column = 0, clear hold_full, shifter count, emitted count and underrun; go to TXT.
- FSM states: IDLE, TXT, CHR, CAP, WAIT.
  - IDLE: no fetch; outputs hold last address.
  - TXT: txt_addr = base + column (mod 2^TXT_AW) → CHR.
  - CHR: rom_addr = {txt_data, font_row}; column++ → CAP.
  - CAP: hold = rom_data, hold_full = 1 → WAIT.
  - WAIT: when hold_full = 0: if column == COLS → IDLE else → TXT. A hold consumed in the same cycle as CAP is handled in WAIT on the next cycle.
- Shifter, on pix_en:
  - count > 0: pixel = shifter[7], shift left, count--, pixel_valid = 1.
  - count == 0 and hold_full: load hold, pixel = hold[7], shifter = hold<<1, count = 7, hold_full = 0, emitted++, pixel_valid = 1.
  - count == 0, no hold, emitted < COLS while busy: pixel = 0, pixel_valid = 0, underrun = 1.
  - Line complete (emitted == COLS and count == 0): pixel = 0, pixel_valid = 0, no underrun.
- No pix_en: pixel and pixel_valid drop to 0 next cycle; shifter holds.
- busy = 1 from cycle after line_start until last pixel of glyph COLS is shifted out and FSM is IDLE.
- line_start mid-line aborts: partial glyph and hold discarded, no underrun from abort.
- Simultaneous line_start and pix_en: line_start wins, pix_en ignored.
- reset: FSM IDLE; txt_addr = 0, rom_addr = 0, pixel = 0, pixel_valid = 0, busy = 0, underrun = 0, all counters and flags 0.

## Timing
- line_start high at cycle T → TXT in T+1 (txt_addr valid), CHR in T+2 (rom_addr valid), CAP in T+3 (rom_data captured), hold_full at T+4.
- First pix_en accepted at T+4 earliest; pixel/pixel_valid registered, appear the cycle after pix_en.
- Glyph fetch: 3 cycles + WAIT; next fetch starts the cycle after hold is loaded into the shifter. With pix_en every cycle, next glyph is ready 4 cycles after load, within the 8-pixel window, so no underrun at full rate.
- Timing generator must assert line_start ≥4 cycles before the first pix_en of the line.

## Test plan
- COLS=4, text RAM row 0 = 0x41,0x42,0x43,0x44, font_row=3, pix_en continuous from T+4 → rom_addr 0x413,0x423,0x433,0x443; 32 pixel_valid cycles, MSB-first bits match ROM bytes; busy low after; underrun 0.
- text_row=2, COLS=80, TXT_AW=11 → first txt_addr = 160; text_row=30 → 2400 mod 2048 = 352 (wrap).
- pix_en first asserted at T+2 → underrun = 1, pixel_valid = 0 for those cycles; next line_start clears underrun.
- pix_en one cycle in three → FSM stalls in WAIT with hold_full; no glyph skipped or repeated across 4 glyphs.
- line_start reissued after 10 pixels → old shifter discarded; new line restarts at column 0 with fresh txt_addr; first pixel is new glyph's bit 7.
- reset asserted mid-fetch (state CHR) → next cycle all outputs 0, FSM IDLE; later line_start works normally.
